// File: rtl/mau_pkg.sv
// Shared types and helpers for the memory access unit: op and error
// encodings, FSM states, alignment check and load-lane extension.
package mau_pkg;

    typedef enum logic [2:0] {
        OP_LW  = 3'b000,
        OP_LH  = 3'b001,
        OP_LHU = 3'b010,
        OP_LB  = 3'b011,
        OP_LBU = 3'b100,
        OP_SW  = 3'b101,
        OP_SH  = 3'b110,
        OP_SB  = 3'b111
    } mau_op_e;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_RANGE    = 2'b10
    } mau_err_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RMW_ISSUE,
        RMW_WAIT,
        WR_ISSUE,
        RESP
    } mau_state_e;

    function automatic logic is_load(mau_op_e op);
        return !(op inside {OP_SW, OP_SH, OP_SB});
    endfunction

    // Word ops need a 4-byte boundary, halfword ops a 2-byte boundary.
    function automatic logic is_misaligned(mau_op_e op, logic [1:0] off);
        case (op)
            OP_LW, OP_SW:         return off != 2'b00;
            OP_LH, OP_LHU, OP_SH: return off[0];
            default:              return 1'b0;
        endcase
    endfunction

    // Byte ops use lane[7:0], halfword ops use the whole 16-bit lane.
    function automatic logic [31:0] extend_lane(mau_op_e op, logic [15:0] lane);
        case (op)
            OP_LH:   return {{16{lane[15]}}, lane};
            OP_LHU:  return {16'h0000, lane};
            OP_LB:   return {{24{lane[7]}}, lane[7:0]};
            OP_LBU:  return {24'h000000, lane[7:0]};
            default: return {16'h0000, lane};
        endcase
    endfunction

endpackage

// File: rtl/mau_if.sv
// Bus bundle around the memory access unit. The master side is the
// pipeline plus the data RAM; the slave side is the access unit itself.
interface mau_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic [1:0]        resp_err;

    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_wdata;
    logic              ram_write_en;
    logic              ram_read_en;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output req_valid, req_op, req_addr, req_wdata, resp_ready, ram_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               ram_address, ram_wdata, ram_write_en, ram_read_en
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, resp_ready, ram_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               ram_address, ram_wdata, ram_write_en, ram_read_en
    );
endinterface

// File: rtl/mau_lane_logic.sv
// Big-endian lane selection: extracts and extends load data from a RAM
// word, and merges halfword/byte store data into a RAM word.
module mau_lane_logic
    import mau_pkg::*;
(
    input  mau_op_e     op,
    input  logic [1:0]  off,
    input  logic [31:0] word,
    input  logic [15:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Pick the addressed byte and halfword; offset 0 is the MSB lane.
    always_comb begin
        byte_lane = word[31:24];
        case (off)
            2'd0:    byte_lane = word[31:24];
            2'd1:    byte_lane = word[23:16];
            2'd2:    byte_lane = word[15:8];
            default: byte_lane = word[7:0];
        endcase
        half_lane = off[1] ? word[15:0] : word[31:16];
    end

    // Extend the selected lane for sub-word loads; LW passes the word through.
    always_comb begin
        load_data = word;
        case (op)
            OP_LH, OP_LHU: load_data = extend_lane(op, half_lane);
            OP_LB, OP_LBU: load_data = extend_lane(op, {8'h00, byte_lane});
            default:       load_data = word;
        endcase
    end

    // Overwrite only the store lane, keeping the rest of the fetched word.
    always_comb begin
        store_word = word;
        if (op == OP_SH) begin
            if (off[1]) store_word[15:0]  = wdata;
            else        store_word[31:16] = wdata;
        end else if (op == OP_SB) begin
            case (off)
                2'd0:    store_word[31:24] = wdata[7:0];
                2'd1:    store_word[23:16] = wdata[7:0];
                2'd2:    store_word[15:8]  = wdata[7:0];
                default: store_word[7:0]   = wdata[7:0];
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end between the EX/MEM register and a word-only RAM.
// One op per request handshake, one registered response per op.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  IDLE      | req_ready high; checks and latches an incoming request
//  RD_ISSUE  | read strobe out for a load
//  RD_WAIT   | RAM word arrives; extract/extend into the response
//  RMW_ISSUE | read strobe out for a halfword/byte store
//  RMW_WAIT  | RAM word arrives; merge store lane into the write word
//  WR_ISSUE  | write strobe out (SW data or merged word)
//  RESP      | response held until resp_ready
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic clk,
    input  logic reset,
    mau_if.slave bus
);
    localparam logic [ADDR_W-1:0] MEM_BYTES = ADDR_W'(MEM_WORDS * 4);

    mau_state_e        state_q, state_d;
    mau_op_e           op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [15:0]       wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    mau_err_e          resp_err_q, resp_err_d;
    logic [ADDR_W-1:0] ram_address_q, ram_address_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_write_en_q, ram_write_en_d;
    logic              ram_read_en_q, ram_read_en_d;

    logic [31:0]       lane_load;
    logic [31:0]       lane_store;
    mau_op_e           in_op;

    assign in_op = mau_op_e'(bus.req_op);

    mau_lane_logic u_lane (
        .op         (op_q),
        .off        (off_q),
        .word       (bus.ram_rdata),
        .wdata      (wdata_q),
        .load_data  (lane_load),
        .store_word (lane_store)
    );

    // Next state and next values of every registered output.
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        off_d          = off_q;
        wdata_d        = wdata_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_err_d     = resp_err_q;
        ram_address_d  = ram_address_q;
        ram_wdata_d    = ram_wdata_q;
        ram_write_en_d = 1'b0;
        ram_read_en_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d          = in_op;
                    off_d         = bus.req_addr[1:0];
                    wdata_d       = bus.req_wdata[15:0];
                    ram_address_d = {bus.req_addr[ADDR_W-1:2], 2'b00};
                    // Misalignment outranks range; erroring ops never touch RAM.
                    if (is_misaligned(in_op, bus.req_addr[1:0])) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = ERR_MISALIGN;
                    end else if (bus.req_addr >= MEM_BYTES) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = '0;
                        resp_err_d   = ERR_RANGE;
                    end else if (is_load(in_op)) begin
                        state_d       = RD_ISSUE;
                        ram_read_en_d = 1'b1;
                    end else if (in_op == OP_SW) begin
                        state_d        = WR_ISSUE;
                        ram_write_en_d = 1'b1;
                        ram_wdata_d    = bus.req_wdata;
                    end else begin
                        state_d       = RMW_ISSUE;
                        ram_read_en_d = 1'b1;
                    end
                end
            end
            RD_ISSUE:  state_d = RD_WAIT;
            RD_WAIT: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = lane_load;
                resp_err_d   = ERR_OK;
            end
            RMW_ISSUE: state_d = RMW_WAIT;
            RMW_WAIT: begin
                state_d        = WR_ISSUE;
                ram_write_en_d = 1'b1;
                ram_wdata_d    = lane_store;
            end
            WR_ISSUE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = '0;
                resp_err_d   = ERR_OK;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    resp_rdata_d = '0;
                    resp_err_d   = ERR_OK;
                end
            end
            default:   state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers; reset abandons any op in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_LW;
            off_q          <= '0;
            wdata_q        <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_err_q     <= ERR_OK;
            ram_address_q  <= '0;
            ram_wdata_q    <= '0;
            ram_write_en_q <= 1'b0;
            ram_read_en_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            off_q          <= off_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_err_q     <= resp_err_d;
            ram_address_q  <= ram_address_d;
            ram_wdata_q    <= ram_wdata_d;
            ram_write_en_q <= ram_write_en_d;
            ram_read_en_q  <= ram_read_en_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_rdata   = resp_rdata_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.ram_address  = ram_address_q;
    assign bus.ram_wdata    = ram_wdata_q;
    assign bus.ram_write_en = ram_write_en_q;
    assign bus.ram_read_en  = ram_read_en_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus random
// ops checked against a byte-array memory model.
module tb_mem_access_unit;
    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 32;
    localparam int MEM_BYTES = MEM_WORDS * 4;

    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                           LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mau_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    mem_access_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Synchronous word RAM seen by the DUT.
    logic [31:0] ram [0:MEM_WORDS-1];
    always @(posedge clk) begin
        if (bus.ram_write_en) ram[bus.ram_address[6:2]] <= bus.ram_wdata;
        if (bus.ram_read_en)  bus.ram_rdata <= ram[bus.ram_address[6:2]];
    end

    // Reference memory as big-endian bytes.
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    function automatic logic [31:0] ref_word(input int b);
        return {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
    endfunction

    function automatic logic [1:0] ref_err(input logic [2:0] op, input logic [31:0] a);
        int unsigned align;
        align = (op == LW || op == SW) ? 4 : (op == LH || op == LHU || op == SH) ? 2 : 1;
        if (a % align != 0) return 2'd1;
        if (a >= 32'(MEM_BYTES)) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input int a);
        case (op)
            LW:      return ref_word(a);
            LH:      return {{16{ref_mem[a][7]}}, ref_mem[a], ref_mem[a+1]};
            LHU:     return {16'h0000, ref_mem[a], ref_mem[a+1]};
            LB:      return {{24{ref_mem[a][7]}}, ref_mem[a]};
            default: return {24'h000000, ref_mem[a]};
        endcase
    endfunction

    task automatic ref_store(input logic [2:0] op, input int a, input logic [31:0] d);
        if (op == SW) begin
            ref_mem[a] = d[31:24]; ref_mem[a+1] = d[23:16];
            ref_mem[a+2] = d[15:8]; ref_mem[a+3] = d[7:0];
        end else if (op == SH) begin
            ref_mem[a] = d[15:8]; ref_mem[a+1] = d[7:0];
        end else if (op == SB) begin
            ref_mem[a] = d[7:0];
        end
    endtask

    // Observations from the latest op; k counts cycles after the accepting edge.
    int          r_rd_cnt, r_wr_cnt, r_rd_k, r_wr_k, r_resp_k;
    logic [31:0] r_rd_addr, r_wr_addr, r_wr_data, r_rdata;
    logic [1:0]  r_err;
    logic        r_excl_bad, r_ready_before;

    task automatic do_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
        r_rd_cnt = 0; r_wr_cnt = 0; r_rd_k = 0; r_wr_k = 0; r_resp_k = 0;
        r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0; r_rdata = '0; r_err = '0;
        r_excl_bad = 1'b0;
        @(negedge clk);
        r_ready_before = bus.req_ready;
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = addr; bus.req_wdata = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.ram_read_en && bus.ram_write_en) r_excl_bad = 1'b1;
            if (bus.ram_read_en) begin r_rd_cnt++; r_rd_k = k; r_rd_addr = bus.ram_address; end
            if (bus.ram_write_en) begin
                r_wr_cnt++; r_wr_k = k; r_wr_addr = bus.ram_address; r_wr_data = bus.ram_wdata;
            end
            if (bus.resp_valid) begin
                r_resp_k = k; r_rdata = bus.resp_rdata; r_err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic finish_resp();
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.resp_ready = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", bus.req_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0", bus.resp_valid); end
        checks++; if (bus.resp_rdata !== 32'h0 || bus.resp_err !== 2'd0) begin
            failures++; $display("FAIL reset_resp got=%h/%0d exp=0/0", bus.resp_rdata, bus.resp_err); end
        checks++; if ({bus.ram_write_en, bus.ram_read_en} !== 2'b00 || bus.ram_address !== 32'h0 || bus.ram_wdata !== 32'h0) begin
            failures++; $display("FAIL reset_ram got we=%b re=%b a=%h d=%h exp=all 0",
                                 bus.ram_write_en, bus.ram_read_en, bus.ram_address, bus.ram_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_store_load();
        do_op(SW, 32'h10, 32'h8899AABB);
        ref_store(SW, 16, 32'h8899AABB);
        checks++; if (r_ready_before !== 1'b1) begin failures++; $display("FAIL sw_ready got=%b exp=1", r_ready_before); end
        checks++; if (r_wr_k !== 1 || r_wr_cnt !== 1 || r_rd_cnt !== 0) begin
            failures++; $display("FAIL sw_strobe got wr_k=%0d wr=%0d rd=%0d exp 1/1/0", r_wr_k, r_wr_cnt, r_rd_cnt); end
        checks++; if (r_wr_addr !== 32'h10 || r_wr_data !== 32'h8899AABB) begin
            failures++; $display("FAIL sw_wdata got a=%h d=%h exp a=00000010 d=8899aabb", r_wr_addr, r_wr_data); end
        checks++; if (r_resp_k !== 2 || r_err !== 2'd0 || r_rdata !== 32'h0) begin
            failures++; $display("FAIL sw_resp got k=%0d err=%0d d=%h exp k=2 err=0 d=0", r_resp_k, r_err, r_rdata); end
        finish_resp();
        checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL sw_release got valid=%b ready=%b exp 0/1", bus.resp_valid, bus.req_ready); end
        do_op(LW, 32'h10, 32'h0);
        checks++; if (r_rd_k !== 1 || r_rd_addr !== 32'h10 || r_wr_cnt !== 0) begin
            failures++; $display("FAIL lw_strobe got rd_k=%0d a=%h wr=%0d exp 1/10/0", r_rd_k, r_rd_addr, r_wr_cnt); end
        checks++; if (r_resp_k !== 3 || r_rdata !== 32'h8899AABB || r_err !== 2'd0) begin
            failures++; $display("FAIL lw_resp got k=%0d d=%h err=%0d exp k=3 d=8899aabb err=0", r_resp_k, r_rdata, r_err); end
        finish_resp();
    endtask

    task automatic test_subword_loads();
        logic [2:0]  ops [4] = '{LB, LBU, LHU, LH};
        logic [31:0] adr [4] = '{32'h11, 32'h13, 32'h10, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFFFF99, 32'h000000BB, 32'h00008899, 32'hFFFFAABB};
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], adr[i], 32'h0);
            checks++; if (r_rdata !== exp[i] || r_err !== 2'd0 || r_resp_k !== 3) begin
                failures++; $display("FAIL subword_%0d got d=%h err=%0d k=%0d exp d=%h err=0 k=3",
                                     i, r_rdata, r_err, r_resp_k, exp[i]); end
            finish_resp();
        end
    endtask

    task automatic test_rmw();
        do_op(SH, 32'h12, 32'h00001234);
        ref_store(SH, 18, 32'h00001234);
        checks++; if (r_rd_k !== 1 || r_wr_k !== 3 || r_rd_cnt !== 1 || r_wr_cnt !== 1) begin
            failures++; $display("FAIL sh_strobes got rd_k=%0d wr_k=%0d rd=%0d wr=%0d exp 1/3/1/1",
                                 r_rd_k, r_wr_k, r_rd_cnt, r_wr_cnt); end
        checks++; if (r_wr_data !== 32'h88991234 || r_wr_addr !== 32'h10) begin
            failures++; $display("FAIL sh_wdata got a=%h d=%h exp a=00000010 d=88991234", r_wr_addr, r_wr_data); end
        checks++; if (r_resp_k !== 4 || r_err !== 2'd0) begin
            failures++; $display("FAIL sh_resp got k=%0d err=%0d exp k=4 err=0", r_resp_k, r_err); end
        finish_resp();
        do_op(SB, 32'h10, 32'h00000055);
        ref_store(SB, 16, 32'h00000055);
        checks++; if (r_wr_data !== 32'h55991234 || r_wr_k !== 3) begin
            failures++; $display("FAIL sb_wdata got d=%h k=%0d exp d=55991234 k=3", r_wr_data, r_wr_k); end
        finish_resp();
    endtask

    task automatic test_errors();
        logic [2:0]  ops [5] = '{LH, SW, LH, SW, LBU};
        logic [31:0] adr [5] = '{32'h01, 32'h80, 32'h81, 32'hFFFFFFFC, 32'h80};
        logic [1:0]  exp [5] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd2};
        for (int i = 0; i < 5; i++) begin
            do_op(ops[i], adr[i], 32'hDEADBEEF);
            checks++; if (r_err !== exp[i] || r_rdata !== 32'h0 || r_resp_k !== 1 || (r_rd_cnt + r_wr_cnt) !== 0) begin
                failures++; $display("FAIL err_%0d got err=%0d d=%h k=%0d strobes=%0d exp err=%0d d=0 k=1 strobes=0",
                                     i, r_err, r_rdata, r_resp_k, r_rd_cnt + r_wr_cnt, exp[i]); end
            finish_resp();
        end
        do_op(LW, 32'h7C, 32'h0);
        checks++; if (r_err !== 2'd0 || r_rdata !== ref_load(LW, 124)) begin
            failures++; $display("FAIL last_word got err=%0d d=%h exp err=0 d=%h", r_err, r_rdata, ref_load(LW, 124)); end
        finish_resp();
    endtask

    task automatic test_backpressure();
        logic [31:0] held_d;
        logic [1:0]  held_e;
        int          strobes;
        do_op(LW, 32'h20, 32'h0);
        held_d = r_rdata; held_e = r_err; strobes = 0;
        checks++; if (held_d !== ref_load(LW, 32)) begin
            failures++; $display("FAIL bp_data got=%h exp=%h", held_d, ref_load(LW, 32)); end
        bus.req_valid = 1'b1; bus.req_op = SW; bus.req_addr = 32'h20; bus.req_wdata = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.ram_read_en || bus.ram_write_en) strobes++;
            checks++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== held_d || bus.resp_err !== held_e || bus.req_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold_%0d got v=%b d=%h e=%0d rdy=%b exp v=1 d=%h e=%0d rdy=0",
                                     i, bus.resp_valid, bus.resp_rdata, bus.resp_err, bus.req_ready, held_d, held_e); end
        end
        bus.req_valid = 1'b0;
        finish_resp();
        repeat (3) begin
            @(negedge clk);
            if (bus.ram_read_en || bus.ram_write_en) strobes++;
        end
        checks++; if (strobes !== 0) begin failures++; $display("FAIL bp_ignored got strobes=%0d exp=0", strobes); end
        do_op(LW, 32'h20, 32'h0);
        checks++; if (r_rdata !== ref_load(LW, 32)) begin
            failures++; $display("FAIL bp_mem got=%h exp=%h", r_rdata, ref_load(LW, 32)); end
        finish_resp();
    endtask

    task automatic test_reset_abort();
        int late;
        late = 0;
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_op = SB; bus.req_addr = 32'h10; bus.req_wdata = 32'h000000A7;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
            failures++; $display("FAIL abort_state got rdy=%b v=%b exp 1/0", bus.req_ready, bus.resp_valid); end
        for (int i = 0; i < 8; i++) begin
            if (bus.ram_write_en || bus.ram_read_en || bus.resp_valid) late++;
            @(negedge clk);
        end
        checks++; if (late !== 0) begin failures++; $display("FAIL abort_activity got=%0d exp=0", late); end
        do_op(LW, 32'h10, 32'h0);
        checks++; if (r_rdata !== ref_word(16)) begin
            failures++; $display("FAIL abort_mem got=%h exp=%h", r_rdata, ref_word(16)); end
        finish_resp();
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            logic [2:0]  op;
            logic [31:0] addr, wdata, e_rdata, e_wdata;
            logic [1:0]  e_err;
            int          sel, e_rd, e_wr, e_wr_k, e_resp;
            op = 3'($urandom_range(0, 7));
            wdata = $urandom();
            sel = int'($urandom_range(0, 9));
            if (sel < 7) begin
                addr = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
                if (op == LH || op == LHU || op == SH) addr = addr + 32'($urandom_range(0, 1) * 2);
                else if (op == LB || op == LBU || op == SB) addr = addr + 32'($urandom_range(0, 3));
            end else if (sel == 7) addr = 32'($urandom_range(0, MEM_BYTES - 1));
            else if (sel == 8) addr = 32'($urandom_range(MEM_BYTES, MEM_BYTES + 64));
            else addr = $urandom();
            e_err = ref_err(op, addr);
            e_rdata = '0; e_wdata = '0; e_rd = 0; e_wr = 0; e_wr_k = 0; e_resp = 1;
            if (e_err == 2'd0) begin
                if (op < SW) begin
                    e_rd = 1; e_resp = 3; e_rdata = ref_load(op, int'(addr));
                end else begin
                    ref_store(op, int'(addr), wdata);
                    e_wdata = ref_word(int'(addr) & ~3);
                    e_wr = 1;
                    if (op == SW) begin e_wr_k = 1; e_resp = 2; end
                    else begin e_rd = 1; e_wr_k = 3; e_resp = 4; end
                end
            end
            do_op(op, addr, wdata);
            checks++; if (r_err !== e_err || r_rdata !== e_rdata || r_resp_k !== e_resp) begin
                failures++; $display("FAIL rnd_%0d_resp op=%0d a=%h got err=%0d d=%h k=%0d exp err=%0d d=%h k=%0d",
                                     n, op, addr, r_err, r_rdata, r_resp_k, e_err, e_rdata, e_resp); end
            checks++; if (r_rd_cnt !== e_rd || r_wr_cnt !== e_wr || r_excl_bad !== 1'b0) begin
                failures++; $display("FAIL rnd_%0d_strobes op=%0d a=%h got rd=%0d wr=%0d both=%b exp rd=%0d wr=%0d both=0",
                                     n, op, addr, r_rd_cnt, r_wr_cnt, r_excl_bad, e_rd, e_wr); end
            if (e_wr == 1) begin
                checks++; if (r_wr_k !== e_wr_k || r_wr_data !== e_wdata || r_wr_addr !== {addr[31:2], 2'b00}) begin
                    failures++; $display("FAIL rnd_%0d_write op=%0d a=%h got k=%0d d=%h wa=%h exp k=%0d d=%h wa=%h",
                                         n, op, addr, r_wr_k, r_wr_data, r_wr_addr, e_wr_k, e_wdata, {addr[31:2], 2'b00}); end
            end
            if (e_rd == 1) begin
                checks++; if (r_rd_k !== 1 || r_rd_addr !== {addr[31:2], 2'b00}) begin
                    failures++; $display("FAIL rnd_%0d_read op=%0d got k=%0d a=%h exp k=1 a=%h",
                                         n, op, r_rd_k, r_rd_addr, {addr[31:2], 2'b00}); end
            end
            finish_resp();
            checks++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) begin
                failures++; $display("FAIL rnd_%0d_release got rdy=%b v=%b exp 1/0", n, bus.req_ready, bus.resp_valid); end
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'($urandom());
        for (int w = 0; w < MEM_WORDS; w++) ram[w] = ref_word(w * 4);
        test_reset();
        test_store_load();
        test_subword_loads();
        test_rmw();
        test_errors();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
